// File: rtl/snake_head_stepper.sv
// -----------------------------------------------------------------------------
// snake_head_stepper
//
// Moves the snake head one grid cell per movement tick. Turns arrive as
// direction changes from the key front end. They are buffered in a small
// FIFO so that a quick burst of key presses between two ticks is not lost.
// Wall collisions freeze the head and latch the dead flag until reset.
//
// Ports
//   i_clock        system clock
//   i_reset        asynchronous, active-high reset
//   i_game_start   level, high once the game has started (sticky upstream)
//   i_direction    requested direction (`UP_DIR/`DOWN_DIR/`LEFT_DIR/`RIGHT_DIR)
//   i_pause        level, freezes movement while high
//   o_head_x       current head column
//   o_head_y       current head row
//   o_heading      direction applied on the most recent step
//   o_step         one-cycle pulse on each cycle the head moves
//   o_dead         high once a wall hit occurs, held until reset
//   o_queue_count  number of pending turns in the FIFO
// -----------------------------------------------------------------------------

`ifndef UP_DIR
`define UP_DIR    2'd0
`endif
`ifndef DOWN_DIR
`define DOWN_DIR  2'd1
`endif
`ifndef LEFT_DIR
`define LEFT_DIR  2'd2
`endif
`ifndef RIGHT_DIR
`define RIGHT_DIR 2'd3
`endif

module snake_head_stepper #(
    parameter int GRID_W      = 32,
    parameter int GRID_H      = 24,
    parameter int TICK_DIV    = 5000000,
    parameter int QUEUE_DEPTH = 2,
    parameter int START_X     = 16,
    parameter int START_Y     = 12
) (
    input  logic                             i_clock,
    input  logic                             i_reset,
    input  logic                             i_game_start,
    input  logic [1:0]                       i_direction,
    input  logic                             i_pause,
    output logic [$clog2(GRID_W)-1:0]        o_head_x,
    output logic [$clog2(GRID_H)-1:0]        o_head_y,
    output logic [1:0]                       o_heading,
    output logic                             o_step,
    output logic                             o_dead,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0] o_queue_count
);

    localparam int XW = $clog2(GRID_W);
    localparam int YW = $clog2(GRID_H);
    localparam int CW = $clog2(QUEUE_DEPTH + 1);
    localparam int TW = $clog2(TICK_DIV);
    // A one-entry FIFO still needs a one-bit index.
    localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;

    localparam logic [XW-1:0] X_MAX      = XW'(GRID_W - 1);
    localparam logic [YW-1:0] Y_MAX      = YW'(GRID_H - 1);
    localparam logic [XW-1:0] X_START    = XW'(START_X);
    localparam logic [YW-1:0] Y_START    = YW'(START_Y);
    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [CW-1:0] COUNT_FULL = CW'(QUEUE_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSED,
        DEAD
    } state_t;

    state_t          state_q;
    state_t          state_d;

    logic [TW-1:0]   tick_q;
    logic [1:0]      last_dir_q;
    logic [1:0]      fifo_q [QUEUE_DEPTH];

    // Combinational decode of the current cycle.
    logic            step_now;
    logic            fifo_empty;
    logic            fifo_full;
    logic [PW-1:0]   tail_idx;
    logic [PW-1:0]   push_idx;
    logic [1:0]      ref_dir;
    logic            capture_en;
    logic            push;
    logic            pop;
    logic [1:0]      new_heading;
    logic            hit_wall;
    logic [XW-1:0]   next_x;
    logic [YW-1:0]   next_y;
    logic            move;
    logic            die;

    function automatic logic [1:0] reverse_dir(input logic [1:0] d);
        logic [1:0] r;
        case (d)
            `UP_DIR:    r = `DOWN_DIR;
            `DOWN_DIR:  r = `UP_DIR;
            `LEFT_DIR:  r = `RIGHT_DIR;
            `RIGHT_DIR: r = `LEFT_DIR;
            default:    r = d;
        endcase
        return r;
    endfunction

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    // NOTE: state is written with non-blocking assignments so every register
    // samples the values from before the edge, regardless of block order.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next state. A wall hit takes priority over a pause request that
    // lands on the same step cycle.
    // -------------------------------------------------------------------------
    // NOTE: defaults come first so every path assigns state_d and no latch
    // is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (i_game_start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (die) begin
                    state_d = DEAD;
                end else if (i_pause) begin
                    state_d = PAUSED;
                end
            end
            PAUSED: begin
                if (!i_pause) begin
                    state_d = RUN;
                end
            end
            DEAD: begin
                state_d = DEAD;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Turn capture, FIFO control and next-cell calculation
    // -------------------------------------------------------------------------
    always_comb begin
        step_now    = (state_q == RUN) && (tick_q == TICK_LAST);
        fifo_empty  = (o_queue_count == '0);
        fifo_full   = (o_queue_count == COUNT_FULL);
        tail_idx    = PW'(o_queue_count - CW'(1));

        // A new turn is judged against the last queued turn, or against the
        // current heading when nothing is queued. Only pre-cycle contents are
        // used, so a same-cycle pop does not change the decision.
        ref_dir     = fifo_empty ? o_heading : fifo_q[tail_idx];
        capture_en  = (state_q == RUN) || (state_q == PAUSED);
        push        = capture_en
                      && (i_direction != last_dir_q)
                      && !fifo_full
                      && (i_direction != ref_dir)
                      && (i_direction != reverse_dir(ref_dir));
        pop         = step_now && !fifo_empty;

        // On a simultaneous pop the entries shift down by one, so the new
        // turn lands one slot lower than the current count.
        push_idx    = pop ? tail_idx : PW'(o_queue_count);

        new_heading = pop ? fifo_q[0] : o_heading;

        // Bounds are tested before any arithmetic, so the subtractions
        // below never wrap.
        hit_wall = 1'b0;
        next_x   = o_head_x;
        next_y   = o_head_y;
        case (new_heading)
            `UP_DIR: begin
                if (o_head_y == '0) hit_wall = 1'b1;
                else                next_y   = o_head_y - YW'(1);
            end
            `DOWN_DIR: begin
                if (o_head_y == Y_MAX) hit_wall = 1'b1;
                else                   next_y   = o_head_y + YW'(1);
            end
            `LEFT_DIR: begin
                if (o_head_x == '0) hit_wall = 1'b1;
                else                next_x   = o_head_x - XW'(1);
            end
            `RIGHT_DIR: begin
                if (o_head_x == X_MAX) hit_wall = 1'b1;
                else                   next_x   = o_head_x + XW'(1);
            end
            default: begin
                hit_wall = 1'b0;
            end
        endcase

        move = step_now && !hit_wall;
        die  = step_now &&  hit_wall;
    end

    // -------------------------------------------------------------------------
    // Tick divider and direction-change detector
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            tick_q     <= '0;
            last_dir_q <= `LEFT_DIR;
        end else begin
            // Tracked in every state so a key held across IDLE or DEAD is
            // not mistaken for a fresh turn later.
            last_dir_q <= i_direction;
            if (state_q == RUN) begin
                if (tick_q == TICK_LAST) begin
                    tick_q <= '0;
                end else begin
                    tick_q <= tick_q + TW'(1);
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Turn FIFO: entry 0 is the oldest turn, entries shift down on a pop.
    // -------------------------------------------------------------------------
    // NOTE: the FIFO entries are reset as well. The array is only a few bits
    // and a defined power-up value keeps the tail compare free of X.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                fifo_q[i] <= `LEFT_DIR;
            end
            o_queue_count <= '0;
        end else begin
            if (pop) begin
                for (int i = 0; i < QUEUE_DEPTH - 1; i++) begin
                    fifo_q[i] <= fifo_q[i+1];
                end
            end
            // Placed after the shift so that it wins for the same slot.
            if (push) begin
                fifo_q[push_idx] <= i_direction;
            end
            case ({push, pop})
                2'b10:   o_queue_count <= o_queue_count + CW'(1);
                2'b01:   o_queue_count <= o_queue_count - CW'(1);
                default: o_queue_count <= o_queue_count;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Head position, heading and status outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            o_head_x  <= X_START;
            o_head_y  <= Y_START;
            o_heading <= `LEFT_DIR;
            o_step    <= 1'b0;
            o_dead    <= 1'b0;
        end else begin
            o_step <= move;
            if (step_now) begin
                // The heading follows the popped turn even on a fatal step,
                // so the renderer can show which wall was hit.
                o_heading <= new_heading;
            end
            if (move) begin
                o_head_x <= next_x;
                o_head_y <= next_y;
            end
            if (die) begin
                o_dead <= 1'b1;
            end
        end
    end

endmodule
